// File: rtl/mips_cpu_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; latency WIDTH+2 cycles (2 for multiplies with
// MIPS_CPU_MULDIV_FAST_MUL_EN); no backpressure: start is ignored while busy, and busy stalls the pipeline.
module mips_cpu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic               sa, sb;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (signed_op && B[WIDTH-1]) ? -B : B;

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: the shifted remainder needs one extra bit before the trial subtract.
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opnd};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  logic               neg_res, div0;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign neg_res  = ~op_q[0] & (sa ^ sb);
  assign div0     = (opnd == '0);
  assign prod_fix = neg_res ? -acc : acc;
  assign q_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = (~op_q[0] & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (div0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = r_fix;
        fix_lo = q_fix;
      end
    end
  end

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      opnd  <= '0;
      a_raw <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            sa    <= signed_op & A[WIDTH-1];
            sb    <= signed_op & B[WIDTH-1];
            a_raw <= A;
            cnt   <= '0;
            busy  <= 1'b1;
            if (op[1]) begin
              opnd  <= mag_b;
              acc   <= {{WIDTH{1'b0}}, mag_a};
              state <= RUN;
            end else begin
              opnd  <= mag_a;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
              acc   <= fast_prod;
              state <= FIX;
`else
              acc   <= {{WIDTH{1'b0}}, mag_b};
              state <= RUN;
`endif
            end
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for mips_cpu_muldiv_ctrl: vector table plus multi-cycle corner sequences.
module tb_mips_cpu_muldiv_ctrl;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vec[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    return o[1] ? 34 : 2;
`else
    return (o == 2'b11) ? 34 : 34;
`endif
  endfunction

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int  cyc;
    logic got, gap;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0; A = 32'h0; B = 32'h0; op = 2'd0;
    cyc = 0; got = 1'b0; gap = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        cyc = i;
      end else if (!busy) gap = 1'b1;
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(cyc), 32'(lat_of(o)));
    chk({nm, " busy_gap"}, 32'(gap), 32'd0);
    chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask

  logic [1:0]  fl_op;
  logic [31:0] fl_a, fl_b, fl_eh, fl_el;
  int          n_done;

  initial begin
    vec[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vec[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vec[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vec[3]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vec[4]  = '{DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vec[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vec[6]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vec[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vec[8]  = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vec[9]  = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
    vec[10] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    fl_op = DIVU; fl_a = 32'd1000; fl_b = 32'd7; fl_eh = 32'd6; fl_el = 32'd142;
`else
    fl_op = MULT; fl_a = 32'd5; fl_b = 32'd6; fl_eh = 32'd0; fl_el = 32'd30;
`endif

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; A = '0; B = '0; wdata = '0;
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Consecutive entries start on the done cycle, so start-while-done is exercised too.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vec[i].op, vec[i].a, vec[i].b, vec[i].eh, vec[i].el);
    @(negedge clk);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt both hi", hi, 32'hA5A5A5A5);
    chk("mt both lo", lo, 32'hA5A5A5A5);

    // Op in flight: late start and mthi must both be ignored.
    start = 1'b1; op = fl_op; A = fl_a; B = fl_b;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 11) chk("mthi while busy", hi, 32'hA5A5A5A5);
      start = (c == 5);
      op = DIVU; A = 32'd9; B = 32'd3;
      mthi = (c == 10);
      wdata = 32'hDEADBEEF;
    end
    start = 1'b0; mthi = 1'b0;
    chk("busy ignore done count", 32'(n_done), 32'd1);
    chk("busy ignore hi", hi, fl_eh);
    chk("busy ignore lo", lo, fl_el);

    // MT write alongside an accepted start lands first, then the result overwrites it.
    start = 1'b1; op = DIVU; A = 32'd100; B = 32'd7;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    @(posedge clk);
    #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("mt with start hi", hi, 32'h55);
    chk("mt with start lo", lo, 32'h55);
    n_done = 0;
    for (int c = 1; c <= 40 && n_done == 0; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("mt with start done", 32'(n_done), 32'd1);
    chk("mt with start res hi", hi, 32'd2);
    chk("mt with start res lo", lo, 32'd14);
    @(negedge clk);

    // Asynchronous reset mid-divide.
    start = 1'b1; op = DIV; A = 32'hFFFFFFF9; B = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 mtlo = 1'b0;
    chk("post rst lo", lo, 32'h1234);
    chk("post rst hi", hi, 32'd0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("post rst idle", 32'(n_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
